// File: rtl/pe_net_pkg.sv
// Shared definitions for the PE network transmitter: flit layout, FSM encoding, defaults.
package pe_net_pkg;

  localparam int unsigned DATA_WIDTH    = 36;
  localparam int unsigned ADDR_WIDTH    = 4;
  localparam int unsigned PAYLOAD_WIDTH = DATA_WIDTH - ADDR_WIDTH;
  localparam int unsigned ADDR_MSB      = DATA_WIDTH - 1;
  localparam int unsigned ADDR_LSB      = DATA_WIDTH - ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DROP = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]    dest;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } flit_t;

  // Build a default-width flit from its fields.
  function automatic flit_t make_flit(input logic [ADDR_WIDTH-1:0] dest,
                                      input logic [PAYLOAD_WIDTH-1:0] payload);
    flit_t f;
    f.dest    = dest;
    f.payload = payload;
    return f;
  endfunction

endpackage

// File: rtl/pe_tx_skid.sv
// Two-entry registered valid/ready skid buffer; output driven straight from the head register.
module pe_tx_skid #(
  parameter int unsigned DataWidth = 36
) (
  input  logic                 i_clk,
  input  logic                 i_resetn,
  input  logic                 i_valid,
  input  logic [DataWidth-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [DataWidth-1:0] o_data,
  input  logic                 i_ready
);

  logic [DataWidth-1:0] head_q;
  logic [DataWidth-1:0] tail_q;
  logic                 head_vld_q;
  logic                 full_q;
  logic                 push;
  logic                 pop;

  // Ready comes only from the registered full flag, never from i_ready.
  assign push = i_valid & ~full_q;
  assign pop  = head_vld_q & i_ready;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      head_q     <= '0;
      tail_q     <= '0;
      head_vld_q <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      if (push && (!head_vld_q || pop)) begin
        head_q     <= i_data;
        head_vld_q <= 1'b1;
      end else if (push) begin
        tail_q <= i_data;
        full_q <= 1'b1;
      end else if (pop && full_q) begin
        head_q <= tail_q;
        full_q <= 1'b0;
      end else if (pop) begin
        head_vld_q <= 1'b0;
      end
    end
  end

  assign o_ready = ~full_q;
  assign o_valid = head_vld_q;
  assign o_data  = head_q;

endmodule

// File: rtl/pe_net_tx.sv
// PE-side NoC transmitter: validates packet commands, tags payload words with dest, skid-buffers flits.
// Optional PE_NET_TX_STATS_EN adds flit/drop counters.
module pe_net_tx
  import pe_net_pkg::*;
#(
  parameter int unsigned DataWidth = DATA_WIDTH,
  parameter int unsigned AddrWidth = ADDR_WIDTH,
  parameter int unsigned LenWidth  = 8,
  parameter int unsigned MyAddr    = 0,
  parameter int unsigned MaxAddr   = 15
) (
  input  logic                           i_clk,
  input  logic                           i_resetn,
  input  logic                           i_cmd_valid,
  input  logic [AddrWidth-1:0]           i_cmd_dest,
  input  logic [LenWidth-1:0]            i_cmd_len,
  output logic                           o_cmd_ready,
  input  logic [DataWidth-AddrWidth-1:0] i_pld_data,
  input  logic                           i_pld_valid,
  output logic                           o_pld_ready,
  output logic [DataWidth-1:0]           o_data,
  output logic                           o_data_valid,
  input  logic                           i_data_ready,
  output logic                           o_err_drop
`ifdef PE_NET_TX_STATS_EN
  ,
  output logic [31:0]                    o_flit_count,
  output logic [15:0]                    o_drop_count
`endif
);

  tx_state_e             state_q;
  tx_state_e             state_d;
  logic [AddrWidth-1:0]  dest_q;
  logic [LenWidth-1:0]   rem_q;
  logic                  cmd_hs;
  logic                  pld_hs;
  logic                  cmd_illegal;
  logic                  last_word;
  logic                  skid_push;
  logic                  skid_ready;

  assign cmd_hs      = i_cmd_valid & o_cmd_ready;
  assign pld_hs      = i_pld_valid & o_pld_ready;
  assign cmd_illegal = (i_cmd_dest == AddrWidth'(MyAddr)) || (32'(i_cmd_dest) > MaxAddr);
  assign last_word   = (rem_q == '0);
  assign skid_push   = (state_q == ST_SEND) & i_pld_valid;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:          if (cmd_hs) state_d = cmd_illegal ? ST_DROP : ST_SEND;
      ST_SEND, ST_DROP: if (pld_hs && last_word) state_d = ST_IDLE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Ready flags decode only the state and the registered skid full flag.
  always_comb begin
    o_cmd_ready = 1'b0;
    o_pld_ready = 1'b0;
    case (state_q)
      ST_IDLE: o_cmd_ready = 1'b1;
      ST_SEND: o_pld_ready = skid_ready;
      ST_DROP: o_pld_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      dest_q     <= '0;
      rem_q      <= '0;
      o_err_drop <= 1'b0;
    end else begin
      o_err_drop <= cmd_hs & cmd_illegal;
      if (cmd_hs) begin
        dest_q <= i_cmd_dest;
        rem_q  <= i_cmd_len;
      end else if (pld_hs && !last_word) begin
        rem_q <= rem_q - LenWidth'(1);
      end
    end
  end

  pe_tx_skid #(
    .DataWidth (DataWidth)
  ) u_skid (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_valid  (skid_push),
    .i_data   ({dest_q, i_pld_data}),
    .o_ready  (skid_ready),
    .o_valid  (o_data_valid),
    .o_data   (o_data),
    .i_ready  (i_data_ready)
  );

`ifdef PE_NET_TX_STATS_EN
  logic [31:0] flit_count_q;
  logic [15:0] drop_count_q;

  // Flit count wraps naturally; drop count saturates.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      flit_count_q <= '0;
      drop_count_q <= '0;
    end else begin
      if (o_data_valid && i_data_ready) flit_count_q <= flit_count_q + 32'd1;
      if (cmd_hs && cmd_illegal && (drop_count_q != 16'hFFFF)) drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign o_flit_count = flit_count_q;
  assign o_drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_pe_net_tx.sv
// Directed self-checking bench for pe_net_tx (MaxAddr=14); stats checks enabled with PE_NET_TX_STATS_EN.
module tb_pe_net_tx;
  import pe_net_pkg::*;

  logic        i_clk;
  logic        i_resetn;
  logic        i_cmd_valid;
  logic [3:0]  i_cmd_dest;
  logic [7:0]  i_cmd_len;
  logic        o_cmd_ready;
  logic [31:0] i_pld_data;
  logic        i_pld_valid;
  logic        o_pld_ready;
  logic [35:0] o_data;
  logic        o_data_valid;
  logic        i_data_ready;
  logic        o_err_drop;
`ifdef PE_NET_TX_STATS_EN
  logic [31:0] o_flit_count;
  logic [15:0] o_drop_count;
`endif

  int n_checks;
  int n_errors;
  logic [35:0] rx_q[$];

  pe_net_tx #(
    .DataWidth (36),
    .AddrWidth (4),
    .LenWidth  (8),
    .MyAddr    (0),
    .MaxAddr   (14)
  ) dut (
    .i_clk        (i_clk),
    .i_resetn     (i_resetn),
    .i_cmd_valid  (i_cmd_valid),
    .i_cmd_dest   (i_cmd_dest),
    .i_cmd_len    (i_cmd_len),
    .o_cmd_ready  (o_cmd_ready),
    .i_pld_data   (i_pld_data),
    .i_pld_valid  (i_pld_valid),
    .o_pld_ready  (o_pld_ready),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_data_ready (i_data_ready),
    .o_err_drop   (o_err_drop)
`ifdef PE_NET_TX_STATS_EN
    ,
    .o_flit_count (o_flit_count),
    .o_drop_count (o_drop_count)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Record every network-side transfer, sampled half a cycle before the edge that takes it.
  always @(negedge i_clk) begin
    if (i_resetn && o_data_valid && i_data_ready) rx_q.push_back(o_data);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] dest, input logic [7:0] len);
    int g = 0;
    while (!o_cmd_ready && g < 20) begin
      tick();
      g++;
    end
    check("cmd_ready_wait", 64'(o_cmd_ready), 64'h1);
    i_cmd_valid = 1'b1;
    i_cmd_dest  = dest;
    i_cmd_len   = len;
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic feed(input logic [31:0] base, input int n);
    int idx = 0;
    int g   = 0;
    logic took;
    while (idx < n && g < 200) begin
      i_pld_valid = 1'b1;
      i_pld_data  = base + 32'(idx);
      took        = o_pld_ready;
      tick();
      if (took) idx++;
      g++;
    end
    i_pld_valid = 1'b0;
    check("feed_done", 64'(idx), 64'(n));
  endtask

  task automatic check_rx(input string tag, input logic [3:0] dest, input logic [31:0] base, input int n);
    int g = 0;
    while (rx_q.size() < n && g < 100) begin
      tick();
      g++;
    end
    repeat (4) tick();
    check({tag, "_count"}, 64'(rx_q.size()), 64'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++)
      check({tag, "_flit"}, 64'(rx_q[i]), 64'(make_flit(dest, base + 32'(i))));
  endtask

  task automatic drop_pkt(input logic [3:0] dest);
    send_cmd(dest, 8'd1);
    check("drop_err_pulse", 64'(o_err_drop), 64'h1);
    check("drop_pld_ready", 64'(o_pld_ready), 64'h1);
    i_pld_valid = 1'b1;
    i_pld_data  = 32'hDEAD_0000;
    tick();
    check("drop_err_once", 64'(o_err_drop), 64'h0);
    check("drop_pld_ready2", 64'(o_pld_ready), 64'h1);
    i_pld_data = 32'hDEAD_0001;
    tick();
    i_pld_valid = 1'b0;
    check("drop_back_idle", 64'(o_cmd_ready), 64'h1);
  endtask

  initial begin
    int acc;
    logic took;
    n_checks     = 0;
    n_errors     = 0;
    i_resetn     = 1'b0;
    i_cmd_valid  = 1'b0;
    i_cmd_dest   = '0;
    i_cmd_len    = '0;
    i_pld_data   = '0;
    i_pld_valid  = 1'b0;
    i_data_ready = 1'b0;

    repeat (3) tick();
    check("rst_data_valid", 64'(o_data_valid), 64'h0);
    check("rst_data", 64'(o_data), 64'h0);
    check("rst_cmd_ready", 64'(o_cmd_ready), 64'h1);
    check("rst_pld_ready", 64'(o_pld_ready), 64'h0);
    check("rst_err_drop", 64'(o_err_drop), 64'h0);
    i_resetn = 1'b1;
    tick();

    // Basic send: one-cycle latency, back-to-back flits.
    rx_q.delete();
    i_data_ready = 1'b1;
    send_cmd(4'd5, 8'd3);
    check("t1_cmd_ready_low", 64'(o_cmd_ready), 64'h0);
    for (int i = 0; i < 4; i++) begin
      i_pld_valid = 1'b1;
      i_pld_data  = 32'hA0 + 32'(i);
      check("t1_pld_ready", 64'(o_pld_ready), 64'h1);
      tick();
      check("t1_valid", 64'(o_data_valid), 64'h1);
      check("t1_data", 64'(o_data), 64'(36'h5_0000_00A0 + 36'(i)));
    end
    check("t1_cmd_ready_again", 64'(o_cmd_ready), 64'h1);
    i_pld_valid = 1'b0;
    tick();
    check("t1_drained", 64'(o_data_valid), 64'h0);
    check_rx("t1_rx", 4'd5, 32'hA0, 4);

    // Back-pressure: skid takes exactly two words, head held stable.
    rx_q.delete();
    i_data_ready = 1'b0;
    send_cmd(4'd2, 8'd7);
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      i_pld_valid = 1'b1;
      i_pld_data  = 32'hB0 + 32'(acc);
      took        = o_pld_ready;
      tick();
      if (took) acc++;
      check("t2_head_stable", 64'(o_data), 64'h2_0000_00B0);
    end
    i_pld_valid = 1'b0;
    check("t2_accepted", 64'(acc), 64'h2);
    check("t2_pld_ready_low", 64'(o_pld_ready), 64'h0);
    check("t2_valid_held", 64'(o_data_valid), 64'h1);
    i_data_ready = 1'b1;
    feed(32'hB2, 6);
    check_rx("t2_rx", 4'd2, 32'hB0, 8);

    // Illegal destinations: self and above MaxAddr.
    rx_q.delete();
    drop_pkt(4'd0);
    drop_pkt(4'hF);
    repeat (3) tick();
    check("t3_no_flits", 64'(rx_q.size()), 64'h0);
    check("t3_valid_low", 64'(o_data_valid), 64'h0);
`ifdef PE_NET_TX_STATS_EN
    check("t3_drop_count", 64'(o_drop_count), 64'h2);
`endif

    // MaxAddr itself is a legal destination.
    rx_q.delete();
    send_cmd(4'hE, 8'd0);
    check("t3b_no_err", 64'(o_err_drop), 64'h0);
    check("t3b_send_ready", 64'(o_pld_ready), 64'h1);
    feed(32'h77, 1);
    check_rx("t3b_rx", 4'hE, 32'h77, 1);

    // Single-word packet with toggling ready.
    rx_q.delete();
    send_cmd(4'd1, 8'd0);
    i_data_ready = 1'b0;
    i_pld_valid  = 1'b1;
    i_pld_data   = 32'hC5;
    check("t4_pld_ready", 64'(o_pld_ready), 64'h1);
    tick();
    i_pld_valid = 1'b0;
    check("t4_idle_after_word", 64'(o_cmd_ready), 64'h1);
    check("t4_pld_ready_low", 64'(o_pld_ready), 64'h0);
    check("t4_valid", 64'(o_data_valid), 64'h1);
    for (int c = 0; c < 6; c++) begin
      i_data_ready = ~i_data_ready;
      tick();
    end
    check_rx("t4_rx", 4'd1, 32'hC5, 1);
    check("t4_drained", 64'(o_data_valid), 64'h0);

    // Reset mid-packet with one flit held in the skid.
    rx_q.delete();
    i_data_ready = 1'b1;
    send_cmd(4'd4, 8'd3);
    feed(32'hD0, 2);
    i_data_ready = 1'b0;
    check("t5_held_valid", 64'(o_data_valid), 64'h1);
    check("t5_held_data", 64'(o_data), 64'h4_0000_00D1);
    #2;
    i_resetn = 1'b0;
    #1;
    check("t5_async_valid", 64'(o_data_valid), 64'h0);
    check("t5_async_data", 64'(o_data), 64'h0);
    check("t5_async_cmd_ready", 64'(o_cmd_ready), 64'h1);
    tick();
    i_resetn = 1'b1;
    tick();
    check("t5_post_cmd_ready", 64'(o_cmd_ready), 64'h1);
    check("t5_post_pld_ready", 64'(o_pld_ready), 64'h0);
    rx_q.delete();
    i_data_ready = 1'b1;
    send_cmd(4'd3, 8'd0);
    feed(32'hE0, 1);
    check_rx("t5_rx", 4'd3, 32'hE0, 1);

`ifdef PE_NET_TX_STATS_EN
    check("t6_flit_count", 64'(o_flit_count), 64'h1);
    force dut.flit_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.flit_count_q;
    check("t6_preload", 64'(o_flit_count), 64'hFFFF_FFFF);
    rx_q.delete();
    send_cmd(4'd6, 8'd0);
    feed(32'hF0, 1);
    check_rx("t6_rx", 4'd6, 32'hF0, 1);
    check("t6_wrap", 64'(o_flit_count), 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
